// File: rtl/rsa_operand_loader_if.sv
// rsa_operand_loader_if: word stream in, five operands plus exp handshake out.
// Master is the stream source / exp engine side; slave is the loader.
interface rsa_operand_loader_if #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 512
);
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic [OP_W-1:0]   op_x;
   logic [OP_W-1:0]   op_e;
   logic [OP_W-1:0]   op_m;
   logic [OP_W-1:0]   op_rmodm;
   logic [OP_W-1:0]   op_r2modm;
   logic              exp_start;
   logic              exp_done;
   logic              busy;
   logic              job_done;
   logic              err;
   modport master (
      output s_valid, s_data, exp_done,
      input  s_ready, op_x, op_e, op_m, op_rmodm, op_r2modm, exp_start, busy, job_done, err
   );
   modport slave (
      input  s_valid, s_data, exp_done,
      output s_ready, op_x, op_e, op_m, op_rmodm, op_r2modm, exp_start, busy, job_done, err
   );
endinterface

// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader: assembles x, e, m, R mod m, R^2 mod m from a word stream and runs one exp job.
// Define LOADER_ODD_CHECK_EN to reject jobs with an even modulus (err pulse, no exp_start).
module rsa_operand_loader #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 512,
   parameter int N_OPS  = 5
) (
   input logic               clk,
   input logic               reset,
   rsa_operand_loader_if.slave bus
);
   localparam int WPO = OP_W / WORD_W;
   localparam int NW  = N_OPS * WPO;
   localparam int CW  = $clog2(NW);
   typedef enum logic [1:0] {LOAD, START, WAIT, DONE} state_t;
   state_t          state_q;
   logic [CW-1:0]   wcnt_q;
   logic [OP_W-1:0] op_q [N_OPS];
   logic            s_ready_q, exp_start_q, busy_q, job_done_q, err_q;
   logic            acc, last, reject;
   assign acc  = bus.s_valid && s_ready_q;
   assign last = wcnt_q == CW'(NW - 1);
`ifdef LOADER_ODD_CHECK_EN
   // m is fully loaded long before the final word, so its LSB is already valid here
   assign reject = !op_q[2][0];
`else
   assign reject = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD;
         wcnt_q      <= '0;
         for (int i = 0; i < N_OPS; i++) op_q[i] <= '0;
         s_ready_q   <= 1'b0;
         exp_start_q <= 1'b0;
         busy_q      <= 1'b0;
         job_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         exp_start_q <= 1'b0;
         job_done_q  <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            LOAD: begin
               s_ready_q <= 1'b1;
               if (acc) begin
                  wcnt_q <= last ? '0 : wcnt_q + 1'b1;
                  for (int i = 0; i < N_OPS; i++)
                     for (int j = 0; j < WPO; j++)
                        if (wcnt_q == CW'(i * WPO + j)) op_q[i][j*WORD_W +: WORD_W] <= bus.s_data;
                  if (last) begin
                     busy_q      <= 1'b1;
                     s_ready_q   <= 1'b0;
                     state_q     <= reject ? DONE : START;
                     exp_start_q <= !reject;
                     job_done_q  <= reject;
                     err_q       <= reject;
                  end
               end
            end
            START: state_q <= WAIT;
            WAIT: if (bus.exp_done) begin
               state_q    <= DONE;
               job_done_q <= 1'b1;
            end
            DONE: begin
               busy_q    <= 1'b0;
               s_ready_q <= 1'b1;
               state_q   <= LOAD;
            end
            default: state_q <= LOAD;
         endcase
      end
   end
   assign bus.s_ready   = s_ready_q;
   assign bus.op_x      = op_q[0];
   assign bus.op_e      = op_q[1];
   assign bus.op_m      = op_q[2];
   assign bus.op_rmodm  = op_q[3];
   assign bus.op_r2modm = op_q[4];
   assign bus.exp_start = exp_start_q;
   assign bus.busy      = busy_q;
   assign bus.job_done  = job_done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb_rsa_operand_loader: table of directed jobs plus reset / spurious-done sequences.
module tb_rsa_operand_loader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   rsa_operand_loader_if #(.WORD_W(32), .OP_W(512)) bus ();
   rsa_operand_loader dut (.clk(clk), .reset(reset), .bus(bus));
   typedef logic [4:0][511:0] ops_t;
   typedef struct {
      ops_t ops;
      bit   toggle;
      int   hold;
      bit   exp_err;
   } vec_t;
   vec_t vecs [4];
   int checks = 0;
   int failures = 0;
   int starts;
   task automatic chkw(input string n, input logic [511:0] a, input logic [511:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask
   task automatic chkb(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", n, a, e);
      end
   endtask
   function automatic logic [511:0] fill(input logic [31:0] seed, input logic [31:0] lsw, input bit full);
      logic [511:0] r;
      r = '0;
      r[31:0] = lsw;
      if (full) for (int i = 1; i < 16; i++) r[i*32 +: 32] = seed + 32'(i) * 32'h01000193;
      return r;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check_ops(input string n, input ops_t o);
      chkw({n, "_x"}, bus.op_x, o[0]);
      chkw({n, "_e"}, bus.op_e, o[1]);
      chkw({n, "_m"}, bus.op_m, o[2]);
      chkw({n, "_rmodm"}, bus.op_rmodm, o[3]);
      chkw({n, "_r2modm"}, bus.op_r2modm, o[4]);
   endtask
   // Feeds words k0..k1-1; counts exp_start seen before the 80th word is accepted.
   task automatic send(input ops_t o, input int k0, input int k1, input bit tog, output int st);
      int k, cyc;
      logic v, rdy;
      k = k0;
      cyc = 0;
      st = 0;
      while (k < k1 && cyc < 2000) begin
         v = tog ? (cyc % 2 == 0) : 1'b1;
         bus.s_valid = v;
         bus.s_data = o[k/16][32*(k%16) +: 32];
         rdy = bus.s_ready;
         tick();
         if (v && rdy) k++;
         cyc++;
         if (k < 80 && bus.exp_start) st++;
      end
      bus.s_valid = 1'b0;
      chkw("accepted_words", 512'(k), 512'(k1));
   endtask
   task automatic check_job(input vec_t v);
      int bad;
      if (v.exp_err) begin
         chkb("rej_exp_start", bus.exp_start, 1'b0);
         chkb("rej_job_done", bus.job_done, 1'b1);
         chkb("rej_err", bus.err, 1'b1);
         check_ops("rej", v.ops);
         tick();
         chkb("rej_job_done_clr", bus.job_done, 1'b0);
         chkb("rej_busy_clr", bus.busy, 1'b0);
         chkb("rej_ready", bus.s_ready, 1'b1);
      end else begin
         chkb("exp_start", bus.exp_start, 1'b1);
         chkb("ready_low", bus.s_ready, 1'b0);
         chkb("busy", bus.busy, 1'b1);
         chkb("err_low", bus.err, 1'b0);
         check_ops("load", v.ops);
         tick();
         chkb("exp_start_single", bus.exp_start, 1'b0);
         bus.s_valid = 1'b1;
         bus.s_data = 32'hdeadbeef;
         bad = 0;
         repeat (v.hold) begin
            tick();
            if (bus.s_ready || bus.job_done || bus.exp_start) bad++;
         end
         bus.s_valid = 1'b0;
         chkw("wait_quiet", 512'(bad), 512'(0));
         check_ops("hold", v.ops);
         bus.exp_done = 1'b1;
         tick();
         bus.exp_done = 1'b0;
         chkb("job_done", bus.job_done, 1'b1);
         chkb("done_err", bus.err, 1'b0);
         chkb("done_busy", bus.busy, 1'b1);
         chkb("done_ready", bus.s_ready, 1'b0);
         tick();
         chkb("job_done_clr", bus.job_done, 1'b0);
         chkb("busy_clr", bus.busy, 1'b0);
         chkb("ready_back", bus.s_ready, 1'b1);
      end
   endtask
   initial begin
      vecs[0].ops = {fill(32'h5a5a0004, 32'h3c1d2e0f, 1), fill(32'h71c30003, 32'h0badf00d, 1),
                     fill(32'h9f110002, 32'haca7419f, 1), fill(32'h0, 32'h000000b1, 0),
                     fill(32'h24e80001, 32'h6b18ba76, 1)};
      vecs[0].toggle = 0; vecs[0].hold = 3; vecs[0].exp_err = 0;
      vecs[1] = vecs[0];
      vecs[1].toggle = 1; vecs[1].hold = 100;
      vecs[2].ops = {fill(32'hc0de0009, 32'h87654321, 1), fill(32'hbeef0008, 32'h11112222, 1),
                     fill(32'hcafe0007, 32'h12345677, 1), fill(32'h0, 32'h00010001, 0),
                     fill(32'hface0006, 32'hfedcba98, 1)};
      vecs[2].toggle = 0; vecs[2].hold = 5; vecs[2].exp_err = 0;
      vecs[3] = vecs[0];
      vecs[3].ops[2] = fill(32'h9f110002, 32'haca7419e, 1);
      vecs[3].hold = 2;
`ifdef LOADER_ODD_CHECK_EN
      vecs[3].exp_err = 1;
`else
      vecs[3].exp_err = 0;
`endif
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.exp_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_ops("reset", '0);
      chkb("reset_ready", bus.s_ready, 1'b0);
      chkb("reset_start", bus.exp_start, 1'b0);
      chkb("reset_busy", bus.busy, 1'b0);
      chkb("reset_done", bus.job_done, 1'b0);
      chkb("reset_err", bus.err, 1'b0);
      reset = 1'b0;
      tick();
      chkb("ready_after_reset", bus.s_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(vecs[i].ops, 0, 80, vecs[i].toggle, starts);
         chkw("early_start", 512'(starts), 512'(0));
         check_job(vecs[i]);
      end
      // spurious exp_done mid-load must not disturb the word count
      send(vecs[2].ops, 0, 20, 0, starts);
      bus.exp_done = 1'b1;
      tick();
      bus.exp_done = 1'b0;
      chkb("spurious_no_done", bus.job_done, 1'b0);
      chkb("spurious_ready", bus.s_ready, 1'b1);
      send(vecs[2].ops, 20, 80, 0, starts);
      chkw("spurious_early_start", 512'(starts), 512'(0));
      check_job(vecs[2]);
      // reset after 40 words discards the partial load
      send(vecs[0].ops, 0, 40, 0, starts);
      reset = 1'b1;
      #1;
      check_ops("midreset", '0);
      chkb("midreset_ready", bus.s_ready, 1'b0);
      chkb("midreset_busy", bus.busy, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      send(vecs[2].ops, 0, 80, 0, starts);
      chkw("postreset_early_start", 512'(starts), 512'(0));
      check_job(vecs[2]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
